stopwatch: RTL and testbench
============================

// Module: stopwatch
// PURPOSE
//  Count-up stopwatch; the mirror of the countdown timer in the ps1_clock mode set.
//  Counts elapsed seconds from zero while running. Supports pause/resume, lap freeze and clear.
//  Output uses the same 28-bit seconds format the display formatter already consumes for the timer.
//  Sits beside the timer under the mode mux and reads the same debounced button lines.
// PARAMETERS
//  MODE_ID    2'd3         mode value in which the stopwatch owns the buttons
//  WIDTH      28           seconds-count width
//  MAX_COUNT  157_679_999  saturation value (5 years - 1 s)
// PORTS
//  clk          in   1      system clock; one clock domain
//  reset        in   1      asynchronous, active-high reset
//  tick         in   1      1 Hz enable, high for exactly one clk cycle per second
//  mode         in   2      current clock mode
//  startstop    in   1      start/stop button (level, debounced)
//  increment    in   1      lap button in stopwatch mode (level, debounced)
//  decrement    in   1      clear button in stopwatch mode (level, debounced)
//  t_stopwatch  out  WIDTH  displayed seconds: lap value while frozen, else live count
//  running      out  1      counting (RUN or LAP)
//  lap_frozen   out  1      display frozen on a lap capture
//  overflow     out  1      count saturated at MAX_COUNT
// BEHAVIOUR
//  - Buttons are rising-edge detected internally: one clk-cycle pulse per press. Holding a button has no further effect.
//  - Reset (async): state=IDLE; count, lap_reg and t_stopwatch=0; running, lap_frozen and overflow=0.
//  - Reset asserted mid-count aborts immediately; no resume.
//  - States: IDLE (count=0, stopped), RUN, LAP (counting, display frozen), PAUSE.
//  - startstop edge, mode==MODE_ID: IDLE/PAUSE->RUN; RUN->PAUSE; LAP->PAUSE (freeze released).
//  - startstop edge, mode!=MODE_ID: RUN/LAP->PAUSE. IDLE/PAUSE unchanged.
//  - lap edge (increment), mode==MODE_ID:
//    - RUN->LAP: lap_reg<=count, same cycle.
//    - LAP->RUN: freeze released.
//    - Ignored in IDLE and PAUSE.
//  - clear edge (decrement), mode==MODE_ID:
//    - PAUSE->IDLE: count=0, lap_reg=0, overflow=0.
//    - Ignored in RUN, LAP and IDLE.
//  - Lap and clear edges are ignored when mode!=MODE_ID.
//  - Simultaneous edges in one cycle: priority startstop > lap > clear; lower-priority edges are dropped.
//  - tick:
//    - count+1 when the *current* state is RUN or LAP.
//    - A tick in the same cycle as a transition is evaluated against the pre-transition state.
//    - At count==MAX_COUNT the count holds, overflow=1 (sticky until clear), state unchanged.
//  - Outputs are registered. t_stopwatch = (state==LAP) ? lap_reg : count, updated 1 clk after the cause.
//    - Latency: press edge -> state change 1 clk; tick -> t_stopwatch 1 clk.
//  - running = RUN|LAP; lap_frozen = LAP.
//  - Arithmetic is unsigned WIDTH-bit and never wraps.
// STRUCTURE
//  - Shared package clock_pkg: mode encodings (MODE_TIMER=2, MODE_STOPWATCH=3), WIDTH, the 5-year MAX_COUNT, and the stopwatch state enum.
//  - Sub-module edge_pulse: rising-edge detector, one instance per button.
//  - Also reused by the timer when it moves to a single-clock form.
//  - Remainder: one FSM process plus a count/lap datapath.
// TESTING
//  1. Reset, mode=3, press startstop, 5 ticks -> t_stopwatch=5, running=1. Press startstop, 3 ticks -> holds 5, running=0.
//  2. From count=10 RUN: press lap -> lap_frozen=1, shows 10. 4 ticks -> shows 10. Press lap -> shows 14.
//  3. PAUSE at 14, press decrement -> IDLE, count 0. Same press while RUN -> no effect.
//  4. Running at 7 in LAP, mode=2, press startstop -> PAUSE, lap_frozen=0, shows 7. Lap/clear in mode 2 ignored.
//  5. Preload count near MAX_COUNT-1, 3 ticks -> holds 157_679_999, overflow=1. Clear in PAUSE -> 0, overflow=0.
//  6. startstop+lap same cycle as tick while RUN at 20 -> count 21, PAUSE, lap_frozen=0. Async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode set: mode encodings, seconds width,
// the 5-year saturation value and the stopwatch state encoding.
package clock_pkg;

    localparam logic [1:0] MODE_TIMER     = 2'd2;
    localparam logic [1:0] MODE_STOPWATCH = 2'd3;

    localparam int                  SW_WIDTH     = 28;
    localparam logic [SW_WIDTH-1:0] SW_MAX_COUNT = 28'd157_679_999;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_LAP   = 2'd2,
        SW_PAUSE = 2'd3
    } sw_state_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced level: one-cycle pulse per press,
// held levels produce nothing further.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/stopwatch.sv
// Count-up stopwatch with pause, lap freeze and clear. All outputs are
// registered alongside the state so the display sees one coherent update.
//
// state    | meaning
// ---------+------------------------------------------------
// SW_IDLE  | stopped, count cleared
// SW_RUN   | counting, display shows live count
// SW_LAP   | counting, display frozen on lap_reg
// SW_PAUSE | stopped, count retained
module stopwatch
    import clock_pkg::*;
#(
    parameter logic [1:0]       MODE_ID   = MODE_STOPWATCH,
    parameter int               WIDTH     = SW_WIDTH,
    parameter logic [WIDTH-1:0] MAX_COUNT = SW_MAX_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             startstop,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] t_stopwatch,
    output logic             running,
    output logic             lap_frozen,
    output logic             overflow
);

    logic ss_pulse;
    logic lap_pulse;
    logic clr_pulse;

    edge_pulse u_ss_edge  (.clk(clk), .reset(reset), .level(startstop), .pulse(ss_pulse));
    edge_pulse u_lap_edge (.clk(clk), .reset(reset), .level(increment), .pulse(lap_pulse));
    edge_pulse u_clr_edge (.clk(clk), .reset(reset), .level(decrement), .pulse(clr_pulse));

    sw_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             running_q, running_d;
    logic             lap_frozen_q, lap_frozen_d;
    logic             own_mode;

    assign own_mode = (mode == MODE_ID);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lap_d      = lap_q;
        overflow_d = overflow_q;

        // Tick is judged against the pre-transition state.
        if (tick && (state_q == SW_RUN || state_q == SW_LAP)) begin
            if (count_q == MAX_COUNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (ss_pulse) begin
            case (state_q)
                SW_IDLE, SW_PAUSE: if (own_mode) state_d = SW_RUN;
                SW_RUN, SW_LAP:    state_d = SW_PAUSE;
                default:           state_d = state_q;
            endcase
        end else if (lap_pulse && own_mode) begin
            if (state_q == SW_RUN) begin
                state_d = SW_LAP;
                lap_d   = count_q;
            end else if (state_q == SW_LAP) begin
                state_d = SW_RUN;
            end
        end else if (clr_pulse && own_mode && state_q == SW_PAUSE) begin
            state_d    = SW_IDLE;
            count_d    = '0;
            lap_d      = '0;
            overflow_d = 1'b0;
        end

        t_d          = (state_d == SW_LAP) ? lap_d : count_d;
        running_d    = (state_d == SW_RUN) || (state_d == SW_LAP);
        lap_frozen_d = (state_d == SW_LAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SW_IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            overflow_q   <= 1'b0;
            t_q          <= '0;
            running_q    <= 1'b0;
            lap_frozen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            overflow_q   <= overflow_d;
            t_q          <= t_d;
            running_q    <= running_d;
            lap_frozen_q <= lap_frozen_d;
        end
    end

    assign t_stopwatch = t_q;
    assign running     = running_q;
    assign lap_frozen  = lap_frozen_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch; a second instance with a small saturation
// value exercises the overflow path in a practical number of ticks.
module tb_stopwatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [1:0]  mode = 2'd3;
    logic        startstop = 1'b0;
    logic        increment = 1'b0;
    logic        decrement = 1'b0;

    logic [27:0] t_sw, t_ovf;
    logic        run_sw, run_ovf;
    logic        lap_sw, lap_ovf;
    logic        ovf_sw, ovf_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch u_dut (
        .clk(clk), .reset(reset), .tick(tick), .mode(mode),
        .startstop(startstop), .increment(increment), .decrement(decrement),
        .t_stopwatch(t_sw), .running(run_sw), .lap_frozen(lap_sw), .overflow(ovf_sw)
    );

    stopwatch #(.MAX_COUNT(28'd12)) u_ovf (
        .clk(clk), .reset(reset), .tick(tick), .mode(mode),
        .startstop(startstop), .increment(increment), .decrement(decrement),
        .t_stopwatch(t_ovf), .running(run_ovf), .lap_frozen(lap_ovf), .overflow(ovf_ovf)
    );

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic press_ss();
        @(negedge clk); startstop = 1'b1;
        @(negedge clk); startstop = 1'b0;
    endtask

    task automatic press_lap();
        @(negedge clk); increment = 1'b1;
        @(negedge clk); increment = 1'b0;
    endtask

    task automatic press_clr();
        @(negedge clk); decrement = 1'b1;
        @(negedge clk); decrement = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_t", t_sw, 28'd0);
        check("rst_running", {27'd0, run_sw}, 28'd0);
        check("rst_lap", {27'd0, lap_sw}, 28'd0);
        check("rst_ovf", {27'd0, ovf_sw}, 28'd0);
        reset = 1'b0;

        // 1: run 5 s, pause, ticks ignored while paused
        press_ss();
        do_ticks(5);
        check("t1_t_run", t_sw, 28'd5);
        check("t1_running", {27'd0, run_sw}, 28'd1);
        press_ss();
        check("t1_paused", {27'd0, run_sw}, 28'd0);
        do_ticks(3);
        check("t1_t_hold", t_sw, 28'd5);

        // 2: lap freeze at 10, keep counting underneath, release shows 14
        press_ss();
        do_ticks(5);
        press_lap();
        check("t2_lap_frozen", {27'd0, lap_sw}, 28'd1);
        check("t2_t_lap", t_sw, 28'd10);
        do_ticks(4);
        check("t2_t_frozen", t_sw, 28'd10);
        press_lap();
        check("t2_t_release", t_sw, 28'd14);
        check("t2_lap_off", {27'd0, lap_sw}, 28'd0);

        // 3: clear from pause; clear while running ignored
        press_ss();
        press_clr();
        check("t3_t_clear", t_sw, 28'd0);
        check("t3_idle", {27'd0, run_sw}, 28'd0);
        press_ss();
        do_ticks(2);
        press_clr();
        check("t3_t_run_clr", t_sw, 28'd2);
        check("t3_run_clr", {27'd0, run_sw}, 28'd1);

        // 4: LAP at 5, count to 7, foreign-mode stop releases freeze
        do_ticks(3);
        press_lap();
        do_ticks(2);
        check("t4_t_lap", t_sw, 28'd5);
        mode = 2'd2;
        press_ss();
        check("t4_lap_off", {27'd0, lap_sw}, 28'd0);
        check("t4_stopped", {27'd0, run_sw}, 28'd0);
        check("t4_t_live", t_sw, 28'd7);
        press_lap();
        press_clr();
        check("t4_t_ignored", t_sw, 28'd7);
        check("t4_lap_ignored", {27'd0, lap_sw}, 28'd0);
        press_ss();
        check("t4_no_start", {27'd0, run_sw}, 28'd0);
        mode = 2'd3;

        // 5: saturation on the small instance, clear drops overflow
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        press_ss();
        do_ticks(11);
        check("t5_near_max", t_ovf, 28'd11);
        check("t5_no_ovf", {27'd0, ovf_ovf}, 28'd0);
        do_ticks(1);
        check("t5_at_max", t_ovf, 28'd12);
        do_ticks(2);
        check("t5_hold_max", t_ovf, 28'd12);
        check("t5_ovf_set", {27'd0, ovf_ovf}, 28'd1);
        check("t5_ovf_running", {27'd0, run_ovf}, 28'd1);
        check("t5_main_count", t_sw, 28'd14);
        press_ss();
        press_clr();
        check("t5_t_cleared", t_ovf, 28'd0);
        check("t5_ovf_cleared", {27'd0, ovf_ovf}, 28'd0);

        // 6: startstop+lap+tick together while RUN at 20
        press_ss();
        do_ticks(20);
        check("t6_t_20", t_sw, 28'd20);
        @(negedge clk); startstop = 1'b1; increment = 1'b1; tick = 1'b1;
        @(negedge clk); startstop = 1'b0; increment = 1'b0; tick = 1'b0;
        check("t6_t_21", t_sw, 28'd21);
        check("t6_paused", {27'd0, run_sw}, 28'd0);
        check("t6_no_lap", {27'd0, lap_sw}, 28'd0);
        do_ticks(1);
        check("t6_pause_hold", t_sw, 28'd21);

        // async reset mid-run, outputs clear before any clock edge
        press_ss();
        do_ticks(3);
        check("t6_t_24", t_sw, 28'd24);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        check("t6_rst_t", t_sw, 28'd0);
        check("t6_rst_running", {27'd0, run_sw}, 28'd0);
        check("t6_rst_lap", {27'd0, lap_sw}, 28'd0);
        @(negedge clk); reset = 1'b0;
        do_ticks(2);
        check("t6_no_resume", t_sw, 28'd0);
        check("t6_no_resume_run", {27'd0, run_sw}, 28'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
